mux_stream_rr: RTL and testbench

//   Parametrised N-way, W-bit stream multiplexer with a one-word registered output stage.

---
 rtl/mux_stream_rr_if.sv | 27 ++
 rtl/mux_stream_rr.sv | 106 ++++++++++
 tb/tb_mux_stream_rr.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mux_stream_rr_if.sv
// Stream bundle for the N-way round-robin/fixed-select multiplexer.
// The master side is the producer/consumer environment; the slave side is the mux itself.
interface mux_stream_rr_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 8,
   parameter int SEL_W  = 3
);
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/mux_stream_rr.sv
// N-way W-bit stream multiplexer with a one-word registered output stage.
// Selection is either a fixed external index or round-robin among valid channels;
// the round-robin pointer remembers the last channel granted in round-robin mode.
module mux_stream_rr #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 8,
   parameter int SEL_W  = 3
) (
   input logic             clock,
   input logic             reset_n,
   mux_stream_rr_if.slave  bus
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   logic [SEL_W-1:0] rr_ptr;
   logic             space;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             hi_found;
   logic             lo_found;
   logic [SEL_W-1:0] hi_idx;
   logic [SEL_W-1:0] lo_idx;
   logic             transfer;

   // The output register can take a word when empty or when it is draining this cycle.
   always_comb begin
      space = !bus.out_valid | bus.out_ready;
   end

   // Pick the granted channel: exact index match in fixed mode, otherwise the first
   // valid channel above the pointer, wrapping to the lowest valid one at or below it.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      hi_found  = 1'b0;
      lo_found  = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      if (!bus.mode) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SEL_W'(i);
            end
         end
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
               if (SEL_W'(i) > rr_ptr) begin
                  hi_found = 1'b1;
                  hi_idx   = SEL_W'(i);
               end else begin
                  lo_found = 1'b1;
                  lo_idx   = SEL_W'(i);
               end
            end
         end
         grant_vld = hi_found | lo_found;
         grant_idx = hi_found ? hi_idx : lo_idx;
      end
   end

   // Route the granted channel's word towards the output register.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            grant_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot accept back to the producers, held low while reset is asserted.
   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bus.in_ready[i] = reset_n & space & grant_vld & (grant_idx == SEL_W'(i));
      end
   end

   always_comb begin
      transfer = grant_vld & space;
   end

   // Output register and round-robin pointer; a load and a drain may coincide.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
         rr_ptr        <= LAST_CH;
      end else if (transfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= grant_data;
         bus.out_ch    <= grant_idx;
         if (bus.mode) begin
            rr_ptr <= grant_idx;
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed bench for mux_stream_rr: an 8-channel instance for the main sequences and a
// 6-channel instance for out-of-range fixed selects.
module tb_mux_stream_rr;

   logic clock = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   mux_stream_rr_if #(.WIDTH(16), .NUM_CH(8), .SEL_W(3)) busA ();
   mux_stream_rr_if #(.WIDTH(16), .NUM_CH(6), .SEL_W(3)) busB ();

   mux_stream_rr #(.WIDTH(16), .NUM_CH(8), .SEL_W(3)) dutA (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (busA)
   );

   mux_stream_rr #(.WIDTH(16), .NUM_CH(6), .SEL_W(3)) dutB (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (busB)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic m, input logic [2:0] s, input logic [7:0] v,
                                input logic r);
      busA.mode      = m;
      busA.sel       = s;
      busA.in_valid  = v;
      busA.out_ready = r;
   endtask

   // Linear directed sequence; inputs change at falling edges, outputs sampled there too.
   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < 8; i++) busA.in_data[i*16 +: 16] = 16'h1000 + 16'(i);
      for (int i = 0; i < 6; i++) busB.in_data[i*16 +: 16] = 16'h2000 + 16'(i);
      busB.mode      = 1'b0;
      busB.sel       = 3'd0;
      busB.in_valid  = 6'h00;
      busB.out_ready = 1'b1;
      applyStimulus(1'b0, 3'd0, 8'hFF, 1'b1);

      // Reset state, with inputs valid that must not be accepted.
      #2;
      checkOutput("rst_out_valid", 32'(busA.out_valid), 32'h0);
      checkOutput("rst_out_data",  32'(busA.out_data),  32'h0);
      checkOutput("rst_out_ch",    32'(busA.out_ch),    32'h0);
      checkOutput("rst_in_ready",  32'(busA.in_ready),  32'h0);

      // Fixed select of channel 5.
      @(negedge clock);
      busA.in_data[5*16 +: 16] = 16'h5A5A;
      applyStimulus(1'b0, 3'd5, 8'h20, 1'b1);
      reset_n = 1'b1;
      #1 checkOutput("fix_in_ready", 32'(busA.in_ready), 32'h20);
      @(negedge clock);
      checkOutput("fix_out_valid", 32'(busA.out_valid), 32'h1);
      checkOutput("fix_out_data",  32'(busA.out_data),  32'h5A5A);
      checkOutput("fix_out_ch",    32'(busA.out_ch),    32'h5);
      busA.in_valid = 8'h00;
      @(negedge clock);
      checkOutput("drain_out_valid", 32'(busA.out_valid), 32'h0);
      checkOutput("drain_keep_data", 32'(busA.out_data),  32'h5A5A);
      checkOutput("drain_keep_ch",   32'(busA.out_ch),    32'h5);
      busA.in_data[5*16 +: 16] = 16'h1005;

      // Round-robin with all channels valid: 0..7 then 0, no bubbles.
      applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
      for (int k = 0; k < 9; k++) begin
         @(negedge clock);
         checkOutput($sformatf("rr_all_ch%0d", k),    32'(busA.out_ch),    32'(k % 8));
         checkOutput($sformatf("rr_all_data%0d", k),  32'(busA.out_data),  32'h1000 + 32'(k % 8));
         checkOutput($sformatf("rr_all_valid%0d", k), 32'(busA.out_valid), 32'h1);
      end

      // Backpressure: output full, consumer stalls 4 cycles, then resumes.
      busA.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 checkOutput($sformatf("stall_in_ready%0d", k), 32'(busA.in_ready), 32'h0);
         @(negedge clock);
         checkOutput($sformatf("stall_data%0d", k),  32'(busA.out_data),  32'h1000);
         checkOutput($sformatf("stall_valid%0d", k), 32'(busA.out_valid), 32'h1);
      end
      busA.out_ready = 1'b1;
      #1 checkOutput("resume_in_ready", 32'(busA.in_ready), 32'h02);
      @(negedge clock);
      checkOutput("resume_ch",   32'(busA.out_ch),   32'h1);
      checkOutput("resume_data", 32'(busA.out_data), 32'h1001);

      // Asynchronous reset mid-stream, away from any clock edge.
      #3 reset_n = 1'b0;
      #1;
      checkOutput("async_out_valid", 32'(busA.out_valid), 32'h0);
      checkOutput("async_out_data",  32'(busA.out_data),  32'h0);
      checkOutput("async_in_ready",  32'(busA.in_ready),  32'h0);
      @(negedge clock);
      checkOutput("async_hold_valid", 32'(busA.out_valid), 32'h0);
      reset_n = 1'b1;
      #1 checkOutput("post_rst_in_ready", 32'(busA.in_ready), 32'h01);
      @(negedge clock);
      checkOutput("post_rst_ch",   32'(busA.out_ch),   32'h0);
      checkOutput("post_rst_data", 32'(busA.out_data), 32'h1000);

      // Only channels 2 and 6 valid after reset: 2,6,2,6 then 2 alone.
      reset_n = 1'b0;
      @(negedge clock);
      applyStimulus(1'b1, 3'd0, 8'h44, 1'b1);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         checkOutput($sformatf("pair_ch%0d", k), 32'(busA.out_ch), (k % 2 == 0) ? 32'h2 : 32'h6);
      end
      busA.in_valid = 8'h04;
      #1 checkOutput("single_in_ready", 32'(busA.in_ready), 32'h04);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checkOutput($sformatf("single_ch%0d", k),   32'(busA.out_ch),   32'h2);
         checkOutput($sformatf("single_data%0d", k), 32'(busA.out_data), 32'h1002);
      end

      // Six-channel instance: select 7 is out of range and must never grant.
      busB.mode      = 1'b0;
      busB.sel       = 3'd7;
      busB.in_valid  = 6'h3F;
      busB.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 checkOutput($sformatf("oor_in_ready%0d", k), 32'(busB.in_ready), 32'h0);
         @(negedge clock);
         checkOutput($sformatf("oor_out_valid%0d", k), 32'(busB.out_valid), 32'h0);
         checkOutput($sformatf("oor_no_x%0d", k),
                     32'($isunknown({busB.out_data, busB.out_ch, busB.out_valid, busB.in_ready})),
                     32'h0);
      end
      busB.sel = 3'd5;
      #1 checkOutput("b_sel5_in_ready", 32'(busB.in_ready), 32'h20);
      @(negedge clock);
      checkOutput("b_sel5_ch",   32'(busB.out_ch),   32'h5);
      checkOutput("b_sel5_data", 32'(busB.out_data), 32'h2005);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
